// File: rtl/reaction_pkg.sv
// Shared state codes for the reaction-timer datapath and the controller's internal FSM encoding.
package reaction_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_TIMING  = 2'd2;
  localparam logic [1:0] ST_DISPLAY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_TIMING,
    S_DISPLAY,
    S_FOUL
  } fsm_t;

endpackage

// File: rtl/key_sync.sv
// Active-low pushbutton conditioner: 2-FF synchronizer plus falling-edge detect, one pulse per press.
module key_sync (
  input  logic Clock,
  input  logic Resetn,
  input  logic keyn,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // All flops rest at 1 (released) so a key held through reset still yields one press.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= keyn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse = prev_p2 & ~sync_p1;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: turns Start/React keys and FLAG into the datapath state code, with foul and timeout.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int MAX_TIME  = 99,
  parameter int FOUL_HOLD = 100
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       StartKn,
  input  logic       ReactKn,
  input  logic       FLAG,
  output logic [1:0] state,
  output logic       Foul,
  output logic       Timeout,
  output logic       Busy
);

  localparam int TW = $clog2(MAX_TIME + 1);
  localparam int FW = $clog2(FOUL_HOLD + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MAX_TIME - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FOUL_HOLD - 1);

  logic start_p;
  logic react_p;

  key_sync u_start (
    .Clock  (Clock),
    .Resetn (Resetn),
    .keyn   (StartKn),
    .pulse  (start_p)
  );

  key_sync u_react (
    .Clock  (Clock),
    .Resetn (Resetn),
    .keyn   (ReactKn),
    .pulse  (react_p)
  );

  fsm_t          fsm;
  logic [TW-1:0] tcnt;
  logic [FW-1:0] fcnt;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      fsm     <= S_IDLE;
      tcnt    <= '0;
      fcnt    <= '0;
      state   <= ST_IDLE;
      Foul    <= 1'b0;
      Timeout <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start_p) begin
            fsm   <= S_DELAY;
            state <= ST_DELAY;
            Busy  <= 1'b1;
          end
        end
        // An early React beats a FLAG arriving in the same cycle.
        S_DELAY: begin
          if (react_p) begin
            fsm   <= S_FOUL;
            fcnt  <= '0;
            state <= ST_IDLE;
            Foul  <= 1'b1;
            Busy  <= 1'b0;
          end else if (FLAG) begin
            fsm   <= S_TIMING;
            tcnt  <= '0;
            state <= ST_TIMING;
          end
        end
        // tcnt counts cycles already presented as state 2, so the last one is MAX_TIME-1.
        S_TIMING: begin
          if (react_p || tcnt == T_LAST) begin
            fsm     <= S_DISPLAY;
            state   <= ST_DISPLAY;
            Busy    <= 1'b0;
            Timeout <= ~react_p;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DISPLAY: begin
          if (start_p) begin
            fsm     <= S_IDLE;
            state   <= ST_IDLE;
            Timeout <= 1'b0;
          end
        end
        S_FOUL: begin
          if (fcnt == F_LAST) begin
            fsm  <= S_IDLE;
            Foul <= 1'b0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: begin
          fsm     <= S_IDLE;
          state   <= ST_IDLE;
          Foul    <= 1'b0;
          Timeout <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: stimulus pushes expected output transitions with their cycle, a monitor checks them.
module tb_reaction_ctrl;

  localparam int MAX_TIME  = 99;
  localparam int FOUL_HOLD = 100;

  logic       Clock   = 1'b0;
  logic       Resetn  = 1'b0;
  logic       StartKn = 1'b1;
  logic       ReactKn = 1'b1;
  logic       FLAG    = 1'b0;
  logic [1:0] state;
  logic       Foul;
  logic       Timeout;
  logic       Busy;

  reaction_ctrl #(.MAX_TIME(MAX_TIME), .FOUL_HOLD(FOUL_HOLD)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .StartKn (StartKn),
    .ReactKn (ReactKn),
    .FLAG    (FLAG),
    .state   (state),
    .Foul    (Foul),
    .Timeout (Timeout),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [4:0] prev;
  logic [4:0] mcur;
  exp_t       me;

  function automatic logic [4:0] ov(input logic [1:0] st, input logic f, input logic t, input logic b);
    return {st, f, t, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_at(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every output change must match the next expected transition, on its cycle.
  always @(negedge Clock) begin
    if (mon_en) begin
      mcur = {state, Foul, Timeout, Busy};
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        me = exp_q.pop_front();
        chk("missed_transition_cycle", cyc, me.cyc);
      end
      if (mcur !== prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transition", mcur, prev);
        end else begin
          me = exp_q.pop_front();
          chk("transition_value", mcur, me.val);
          chk("transition_cycle", cyc, me.cyc);
        end
      end
      prev = mcur;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) step(1);
    step(2);
  endtask

  // Press a key sampled from the next edge; a registered effect appears 3 edges after this negedge.
  task automatic press(input bit is_react, input int hold, input bit exp_chg, input logic [4:0] v);
    if (is_react) ReactKn = 1'b0;
    else          StartKn = 1'b0;
    if (exp_chg) expect_at(cyc + 3, v);
    step(hold);
    ReactKn = 1'b1;
    StartKn = 1'b1;
    step(3);
  endtask

  // From DELAY: raise FLAG after dly cycles, then React so state 2 lasts react_len cycles (<0: never).
  task automatic timing_phase(input int dly, input int react_len);
    int en;
    int r;
    step(dly);
    FLAG = 1'b1;
    en = cyc + 1;
    expect_at(en, ov(2'd2, 1'b0, 1'b0, 1'b1));
    step(1);
    FLAG = 1'b0;
    if (react_len >= 0) begin
      r = en + react_len - 3;
      if (r > cyc) step(r - cyc);
      if (react_len <= MAX_TIME) expect_at(cyc + 3, ov(2'd3, 1'b0, 1'b0, 1'b0));
      else expect_at(en + MAX_TIME, ov(2'd3, 1'b0, 1'b1, 1'b0));
      ReactKn = 1'b0;
      step($urandom_range(1, 4));
      ReactKn = 1'b1;
    end else begin
      expect_at(en + MAX_TIME, ov(2'd3, 1'b0, 1'b1, 1'b0));
    end
    drain();
  endtask

  task automatic full_run(input int start_hold, input bit both, input int dly, input int react_len);
    if (both) ReactKn = 1'b0;
    press(1'b0, start_hold, 1'b1, ov(2'd1, 1'b0, 1'b0, 1'b1));
    timing_phase(dly, react_len);
    press(1'b0, $urandom_range(1, 5), 1'b1, ov(2'd0, 1'b0, 1'b0, 1'b0));
    drain();
  endtask

  initial begin
    int r;
    // Reset with Start held low across release.
    StartKn = 1'b0;
    step(3);
    chk("reset_state", state, 2'd0);
    chk("reset_foul", Foul, 1'b0);
    chk("reset_timeout", Timeout, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    prev   = 5'd0;
    mon_en = 1'b1;
    Resetn = 1'b1;
    expect_at(cyc + 3, ov(2'd1, 1'b0, 1'b0, 1'b1));
    step(6);
    StartKn = 1'b1;
    step(2);
    timing_phase(50, 37);
    press(1'b0, 2, 1'b1, ov(2'd0, 1'b0, 1'b0, 1'b0));
    drain();

    // Normal run and plain timeout.
    full_run(2, 1'b0, 50, 37);
    full_run(3, 1'b0, 10, -1);

    // Boundaries: React exactly on the timeout edge, and one cycle too late.
    full_run(1, 1'b0, 5, MAX_TIME);
    full_run(1, 1'b0, 5, MAX_TIME + 1);
    full_run(1, 1'b0, 5, 3);

    // Start and React together in IDLE; Start held for 500 cycles.
    full_run(2, 1'b1, 20, 40);
    full_run(500, 1'b0, 15, 25);

    // Foul with FLAG arriving on the same cycle as the React pulse.
    press(1'b0, 2, 1'b1, ov(2'd1, 1'b0, 1'b0, 1'b1));
    step($urandom_range(3, 20));
    ReactKn = 1'b0;
    r = cyc;
    expect_at(r + 3, ov(2'd0, 1'b1, 1'b0, 1'b0));
    expect_at(r + 3 + FOUL_HOLD, ov(2'd0, 1'b0, 1'b0, 1'b0));
    step(2);
    FLAG = 1'b1;
    step(1);
    FLAG = 1'b0;
    step(2);
    ReactKn = 1'b1;
    step(20);
    press(1'b0, 2, 1'b0, 5'd0);
    press(1'b1, 2, 1'b0, 5'd0);
    drain();
    full_run(2, 1'b0, 12, 30);

    // Reset pulse while timing, then a fresh run.
    press(1'b0, 2, 1'b1, ov(2'd1, 1'b0, 1'b0, 1'b1));
    FLAG = 1'b1;
    expect_at(cyc + 1, ov(2'd2, 1'b0, 1'b0, 1'b1));
    step(1);
    FLAG = 1'b0;
    step(20);
    Resetn = 1'b0;
    expect_at(cyc + 1, ov(2'd0, 1'b0, 1'b0, 1'b0));
    step(1);
    Resetn = 1'b1;
    drain();
    full_run(2, 1'b0, 8, 44);

    // Randomized runs.
    for (int i = 0; i < 8; i++) begin
      full_run($urandom_range(1, 6), 1'(($urandom_range(0, 3) == 0)),
               $urandom_range(1, 60), $urandom_range(0, 4) == 0 ? -1 : $urandom_range(3, MAX_TIME + 10));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
